// File: rtl/noc_flit_pkg.sv
// Flit type encoding, type-field position and sink error codes shared across the NoC blocks.
`include "params.svh"

package noc_flit_pkg;

  localparam int FLIT_W   = `DW;
  localparam int TYPE_MSB = `DW - 1;
  localparam int TYPE_LSB = `DW - 2;

  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ERR_TIMEOUT = 2'b00,
    ERR_ORPHAN  = 2'b01,
    ERR_NOTAIL  = 2'b10,
    ERR_LEN     = 2'b11
  } err_code_e;

  function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/flee_sink_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances every cycle; stall_nxt flags a
// backpressure cycle for the state the register is about to take.
module flee_sink_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rstn,
  output logic stall_nxt
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign stall_nxt = (lfsr_nxt[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= SEED;
    else       lfsr <= lfsr_nxt;
  end

endmodule

// File: rtl/params.svh
// Global build parameters shared by the NoC blocks; DW is the full flit width including the 2-bit type field.
`ifndef NOC_PARAMS_SVH
`define NOC_PARAMS_SVH
`ifndef DW
`define DW 34
`endif
`endif

// File: rtl/flee_sink.sv
// Ejection-port packet sink: checks flit framing, counts flits/packets, latches the first error.
// Build option FLEE_SINK_BP_EN adds LFSR-driven pseudo-random backpressure on ready_o.
//
// state   | meaning
// IDLE    | between packets, expecting HEAD or SINGLE
// PKT     | packet open, expecting BODY or TAIL
module flee_sink
  import noc_flit_pkg::*;
#(
  parameter int          MAX_LEN   = 16,
  parameter int          TIMEOUT   = 10000,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [FLIT_W-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [31:0]       pkt_cnt_o,
  output logic [31:0]       flit_cnt_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              busy_o
);

  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_e;

  state_e            state, state_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic [IDLE_W-1:0] idle, idle_nxt;
  logic              pkt_inc;
  logic              err_ev;
  err_code_e         err_cause;
  logic              accept;
  flit_type_e        ftype;
  logic              unused_payload;

  assign accept         = valid_i & ready_o;
  assign ftype          = flit_type(data_i);
  assign unused_payload = ^data_i[TYPE_LSB-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      len   <= '0;
      idle  <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      idle  <= idle_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    idle_nxt  = '0;
    pkt_inc   = 1'b0;
    err_ev    = 1'b0;
    err_cause = ERR_TIMEOUT;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (ftype)
            FLIT_HEAD:   begin state_nxt = ST_PKT; len_nxt = LEN_W'(1); end
            FLIT_SINGLE: pkt_inc = 1'b1;
            default:     begin err_ev = 1'b1; err_cause = ERR_ORPHAN; end
          endcase
        end
      end
      ST_PKT: begin
        if (accept) begin
          unique case (ftype)
            // A new head abandons the open packet and starts over.
            FLIT_HEAD: begin
              err_ev = 1'b1; err_cause = ERR_NOTAIL; len_nxt = LEN_W'(1);
            end
            FLIT_SINGLE: begin
              err_ev = 1'b1; err_cause = ERR_NOTAIL;
              state_nxt = ST_IDLE; len_nxt = '0; pkt_inc = 1'b1;
            end
            default: begin
              if (len == LEN_W'(MAX_LEN)) begin
                err_ev = 1'b1; err_cause = ERR_LEN;
                state_nxt = ST_IDLE; len_nxt = '0;
              end else if (ftype == FLIT_BODY) begin
                len_nxt = len + LEN_W'(1);
              end else begin
                state_nxt = ST_IDLE; len_nxt = '0; pkt_inc = 1'b1;
              end
            end
          endcase
        end else if (idle == IDLE_W'(TIMEOUT - 1)) begin
          err_ev = 1'b1; err_cause = ERR_TIMEOUT;
          state_nxt = ST_IDLE; len_nxt = '0;
        end else begin
          idle_nxt = idle + IDLE_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == ST_PKT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_o  <= '0;
      flit_cnt_o <= '0;
      err_o      <= 1'b0;
      err_code_o <= 2'b00;
    end else begin
      if (accept)  flit_cnt_o <= flit_cnt_o + 32'd1;
      if (pkt_inc) pkt_cnt_o  <= pkt_cnt_o + 32'd1;
      if (err_ev && !err_o) begin
        err_o      <= 1'b1;
        err_code_o <= err_cause;
      end
    end
  end

`ifdef FLEE_SINK_BP_EN
  logic stall_nxt;

  flee_sink_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rstn      (rstn),
    .stall_nxt (stall_nxt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_o <= 1'b0;
    else       ready_o <= ~stall_nxt;
  end
`else
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_o <= 1'b0;
    else       ready_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_flee_sink.sv
// Directed testbench for flee_sink: framing, error latching, length limit, timeout and reset.
// With FLEE_SINK_BP_EN defined it also checks the backpressure duty cycle.
module tb_flee_sink;
  import noc_flit_pkg::*;

  logic              clk = 1'b0;
  logic              rstn;
  logic [FLIT_W-1:0] data;
  logic              valid;
  logic              ready;
  logic [31:0]       pkt_cnt;
  logic [31:0]       flit_cnt;
  logic              err;
  logic [1:0]        err_code;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  flee_sink #(.MAX_LEN(16), .TIMEOUT(10000), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_i     (data),
    .valid_i    (valid),
    .ready_o    (ready),
    .pkt_cnt_o  (pkt_cnt),
    .flit_cnt_o (flit_cnt),
    .err_o      (err),
    .err_code_o (err_code),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; holds the flit until it is accepted, returns at the following negedge.
  task automatic send(input flit_type_e t);
    logic ok;
    ok = 1'b0;
    data = '0;
    data[TYPE_LSB-1:0] = (TYPE_LSB)'($urandom);
    data[TYPE_MSB:TYPE_LSB] = t;
    valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    if (!ok) chk("send_accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int cyc, rdy, sent;
    rstn  = 1'b0;
    valid = 1'b0;
    data  = '0;
    #2;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_pkt", pkt_cnt, 32'd0);
    chk("rst_flit", flit_cnt, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk("ready_before_edge", {31'd0, ready}, 32'd0);
    @(negedge clk);
`ifndef FLEE_SINK_BP_EN
    chk("ready_first_edge", {31'd0, ready}, 32'd1);
`endif

    // clean packet
    send(FLIT_HEAD);
    chk("pkt_busy_mid", {31'd0, busy}, 32'd1);
    send(FLIT_BODY);
    send(FLIT_BODY);
    send(FLIT_TAIL);
    chk("pkt_pkt_cnt", pkt_cnt, 32'd1);
    chk("pkt_flit_cnt", flit_cnt, 32'd4);
    chk("pkt_err", {31'd0, err}, 32'd0);
    chk("pkt_busy_end", {31'd0, busy}, 32'd0);

    // orphan body then single
    do_reset();
    send(FLIT_BODY);
    chk("orphan_busy", {31'd0, busy}, 32'd0);
    send(FLIT_SINGLE);
    chk("orphan_err", {31'd0, err}, 32'd1);
    chk("orphan_code", {30'd0, err_code}, 32'd1);
    chk("orphan_flit", flit_cnt, 32'd2);
    chk("orphan_pkt", pkt_cnt, 32'd1);

    // head without tail
    do_reset();
    send(FLIT_HEAD);
    send(FLIT_BODY);
    send(FLIT_HEAD);
    send(FLIT_TAIL);
    chk("notail_code", {30'd0, err_code}, 32'd2);
    chk("notail_err", {31'd0, err}, 32'd1);
    chk("notail_pkt", pkt_cnt, 32'd1);
    chk("notail_flit", flit_cnt, 32'd4);

    // exactly MAX_LEN flits is legal
    do_reset();
    send(FLIT_HEAD);
    for (int i = 0; i < 14; i++) send(FLIT_BODY);
    send(FLIT_TAIL);
    chk("maxlen_ok_pkt", pkt_cnt, 32'd1);
    chk("maxlen_ok_err", {31'd0, err}, 32'd0);

    // one flit over MAX_LEN
    do_reset();
    send(FLIT_HEAD);
    for (int i = 0; i < 15; i++) send(FLIT_BODY);
    chk("len_busy_at_max", {31'd0, busy}, 32'd1);
    chk("len_err_at_max", {31'd0, err}, 32'd0);
    send(FLIT_BODY);
    chk("len_code", {30'd0, err_code}, 32'd3);
    chk("len_err", {31'd0, err}, 32'd1);
    chk("len_busy", {31'd0, busy}, 32'd0);
    chk("len_pkt", pkt_cnt, 32'd0);
    chk("len_flit", flit_cnt, 32'd17);
    // a later error must not overwrite the first cause
    send(FLIT_TAIL);
    chk("sticky_code", {30'd0, err_code}, 32'd3);
    chk("sticky_flit", flit_cnt, 32'd18);

    // timeout
    do_reset();
    send(FLIT_HEAD);
    repeat (9999) @(negedge clk);
    chk("tmo_busy_before", {31'd0, busy}, 32'd1);
    chk("tmo_err_before", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_code", {30'd0, err_code}, 32'd0);

    // reset mid-packet
    do_reset();
    send(FLIT_HEAD);
    send(FLIT_BODY);
    chk("midrst_busy_pre", {31'd0, busy}, 32'd1);
    rstn = 1'b0;
    #2;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_err", {31'd0, err}, 32'd0);
    chk("midrst_flit", flit_cnt, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(FLIT_SINGLE);
    chk("midrst_after_pkt", pkt_cnt, 32'd1);
    chk("midrst_after_err", {31'd0, err}, 32'd0);

`ifdef FLEE_SINK_BP_EN
    do_reset();
    cyc = 0;
    rdy = 0;
    sent = 0;
    data = '0;
    data[TYPE_MSB:TYPE_LSB] = FLIT_SINGLE;
    valid = 1'b1;
    while (sent < 1000 && cyc < 3000) begin
      cyc++;
      if (ready === 1'b1) begin
        rdy++;
        sent++;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    @(negedge clk);
    chk("bp_sent", sent, 32'd1000);
    chk("bp_pkt", pkt_cnt, 32'd1000);
    chk("bp_flit", flit_cnt, 32'd1000);
    chk("bp_duty_ok", {31'd0, (rdy * 100 >= cyc * 70) && (rdy * 100 <= cyc * 80)}, 32'd1);
`else
    chk("nobp_ready_high", {31'd0, ready}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
